pt_load_sequencer: RTL and testbench

//  Upstream stage of the power-test counter banks. Drives one synchronous active-low reset per bank.

---
 rtl/pt_pkg.sv | 15 +
 rtl/pt_load_sequencer_if.sv | 30 +++
 rtl/pt_dwell_timer.sv | 32 +++
 rtl/pt_load_sequencer.sv | 153 +++++++++++++++
 tb/tb_pt_load_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pt_pkg.sv
// Shared definitions for the power-test blocks: sequencer state encoding and
// default sizing of the counter-bank chain.
package pt_pkg;

  localparam int PT_N_BANKS = 3;
  localparam int PT_DWELL_W = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } pt_seq_state_e;

endpackage

// File: rtl/pt_load_sequencer_if.sv
// Control/status bundle between the board-level start/abort logic (master)
// and the load sequencer (slave) that drives the counter-bank resets.
interface pt_load_sequencer_if
  import pt_pkg::*;
#(
  parameter int N_BANKS = PT_N_BANKS,
  parameter int DWELL_W = PT_DWELL_W
);
  localparam int STAGE_W = $clog2(N_BANKS + 1);

  logic                start;
  logic                abort;
  logic [DWELL_W-1:0]  dwell_cycles;
  logic [N_BANKS-1:0]  bank_rst_n;
  logic [STAGE_W-1:0]  stage;
  logic                busy;
  logic                done;
  logic                marker;

  modport master (
    output start, abort, dwell_cycles,
    input  bank_rst_n, stage, busy, done, marker
  );

  modport slave (
    input  start, abort, dwell_cycles,
    output bank_rst_n, stage, busy, done, marker
  );

endinterface

// File: rtl/pt_dwell_timer.sv
// Loadable down-counter used to time each stage of a power-test sequence.
// expire is high while running with the count at zero; the owner is expected
// to reload on expiry, otherwise the count wraps.
module pt_dwell_timer
  import pt_pkg::*;
#(
  parameter int DWELL_W = PT_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               run,
  output logic               expire
);

  logic [DWELL_W-1:0] r_count;

  // Load has priority over counting so an expiry can reload in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (run) begin
      r_count <= r_count - DWELL_W'(1);
    end
  end

  assign expire = run && (r_count == '0);

endmodule

// File: rtl/pt_load_sequencer.sv
// Releases the counter banks one at a time, dwells D cycles per stage, then
// re-asserts them in reverse order, giving a staircase of supply current.
// Build option: define PT_SEQ_LOOP_EN to repeat the sequence until abort/reset
// instead of returning to IDLE after one pass.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | all banks held in reset, waiting for start
//   UP    | stage counts 0..N_BANKS, one more bank released per expiry
//   DOWN  | stage counts N_BANKS-1..0, one bank re-asserted per expiry
//   DONE  | one-cycle done pulse, then IDLE (or UP when looping)
module pt_load_sequencer
  import pt_pkg::*;
#(
  parameter int N_BANKS = PT_N_BANKS,
  parameter int DWELL_W = PT_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  pt_load_sequencer_if.slave bus
);

  localparam int STAGE_W = $clog2(N_BANKS + 1);
  localparam logic [STAGE_W-1:0] LAST = STAGE_W'(N_BANKS);
  localparam logic [STAGE_W-1:0] ONE  = STAGE_W'(1);

  pt_seq_state_e        r_state;
  logic [STAGE_W-1:0]   r_stage;
  logic [N_BANKS-1:0]   r_bank;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_marker;
  logic [DWELL_W-1:0]   r_dwell_m1;

  logic                 w_idle;
  logic                 w_start_acc;
  logic                 w_abort;
  logic                 w_run;
  logic                 w_expire;
  logic                 w_load;
  logic [DWELL_W-1:0]   w_d_m1;
  logic [DWELL_W-1:0]   w_load_val;

  // Bank k runs once more than k banks have been released.
  function automatic logic [N_BANKS-1:0] f_bank(input logic [STAGE_W-1:0] s);
    f_bank = '0;
    for (int k = 0; k < N_BANKS; k++) begin
      f_bank[k] = (s > STAGE_W'(k));
    end
  endfunction

  // A zero dwell would never expire cleanly, so it is treated as one cycle.
  assign w_d_m1      = (bus.dwell_cycles == '0) ? '0 : bus.dwell_cycles - DWELL_W'(1);
  assign w_idle      = (r_state == IDLE);
  assign w_start_acc = w_idle && bus.start && !bus.abort;
  assign w_abort     = bus.abort && !w_idle;
  assign w_run       = (r_state == UP) || (r_state == DOWN);

  // The timer is reloaded on every stage boundary, on the first stage of each
  // pass, and cleared on abort; the input dwell is only looked at from IDLE.
  assign w_load     = w_start_acc || w_abort || w_expire || (r_state == DONE);
  assign w_load_val = w_abort ? '0 : (w_idle ? w_d_m1 : r_dwell_m1);

  pt_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .run      (w_run),
    .expire   (w_expire)
  );

  // Sequencer FSM; bank resets are recomputed from the new stage value so they
  // switch on the same edge as stage and come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_stage    <= '0;
      r_bank     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_marker   <= 1'b0;
      r_dwell_m1 <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= IDLE;
        r_stage <= '0;
        r_bank  <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start_acc) begin
              r_state    <= UP;
              r_stage    <= '0;
              r_bank     <= '0;
              r_busy     <= 1'b1;
              r_dwell_m1 <= w_d_m1;
            end
          end
          UP: begin
            if (w_expire) begin
              r_marker <= ~r_marker;
              if (r_stage != LAST) begin
                r_stage <= r_stage + ONE;
                r_bank  <= f_bank(r_stage + ONE);
              end else begin
                r_state <= DOWN;
                r_stage <= LAST - ONE;
                r_bank  <= f_bank(LAST - ONE);
              end
            end
          end
          DOWN: begin
            if (w_expire) begin
              if (r_stage != '0) begin
                r_stage  <= r_stage - ONE;
                r_bank   <= f_bank(r_stage - ONE);
                r_marker <= ~r_marker;
              end else begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end
          end
          DONE: begin
`ifdef PT_SEQ_LOOP_EN
            r_state <= UP;
            r_stage <= '0;
            r_bank  <= '0;
`else
            r_state <= IDLE;
            r_busy  <= 1'b0;
`endif
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.bank_rst_n = r_bank;
  assign bus.stage      = r_stage;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.marker     = r_marker;

endmodule

// File: tb/tb_pt_load_sequencer.sv
// Scoreboard bench for pt_load_sequencer (N_BANKS=3). Stimulus pushes the
// expected output snapshots with the cycle they must appear in; a monitor pops
// one entry every time the outputs change and compares value and timing.
module tb_pt_load_sequencer;

  localparam int NB = 3;
  localparam int DW = 28;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pt_load_sequencer_if #(.N_BANKS(NB), .DWELL_W(DW)) bus ();

  pt_load_sequencer #(.N_BANKS(NB), .DWELL_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] snap;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prev = '0;
  logic       exp_marker = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // snapshot = {bank_rst_n[2:0], stage[1:0], busy, done, marker}
  function automatic logic [7:0] mk(int stage, bit busy, bit done, bit marker);
    logic [2:0] bank;
    bank = 3'((1 << stage) - 1);
    return {bank, 2'(stage), busy, done, marker};
  endfunction

  function automatic logic [7:0] cur_snap();
    return {bus.bank_rst_n, bus.stage, bus.busy, bus.done, bus.marker};
  endfunction

  always @(negedge clk) begin
    logic [7:0] s;
    ev_t        e;
    s = cur_snap();
    if (mon_en && (s !== prev)) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change: cyc=%0d got=%b, required no change", cyc, s);
      end else begin
        e = q.pop_front();
        if ((e.cyc != cyc) || (e.snap !== s)) begin
          miscompares++;
          $display("FAIL event: got cyc=%0d snap=%b, required cyc=%0d snap=%b",
                   cyc, s, e.cyc, e.snap);
        end
      end
    end
    prev = s;
  end

  task automatic push(int c, int stage, bit busy, bit done);
    ev_t e;
    e.cyc  = c;
    e.snap = mk(stage, busy, done, exp_marker);
    q.push_back(e);
  endtask

  // Expected output changes of one pass whose start was sampled at the end of cycle t0.
  task automatic run_events(int t0, int d, int nchg, bit first, bit with_done, bit busy_after);
    int seq[6];
    seq = '{1, 2, 3, 2, 1, 0};
    if (first) push(t0 + 1, 0, 1'b1, 1'b0);
    for (int i = 0; i < nchg; i++) begin
      exp_marker = ~exp_marker;
      push(t0 + 1 + d * (i + 1), seq[i], 1'b1, 1'b0);
    end
    if (with_done) begin
      push(t0 + 1 + 7 * d, 0, 1'b1, 1'b1);
      push(t0 + 2 + 7 * d, 0, busy_after, 1'b0);
    end
  endtask

  task automatic do_start(int dwell, int d, int nchg, bit with_done, bit busy_after, output int t0);
    @(negedge clk);
    bus.dwell_cycles = DW'(dwell);
    bus.start = 1'b1;
    t0 = cyc;
    run_events(t0, d, nchg, 1'b1, with_done, busy_after);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(int budget);
    int n;
    n = 0;
    while ((q.size() != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d events pending after %0d cycles, required 0", q.size(), budget);
      q.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.dwell_cycles = '0;

    // Reset with random start/abort activity
    repeat (3) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(0, 1));
      bus.abort = 1'($urandom_range(0, 1));
    end
    chk("rst_bank",   8'(bus.bank_rst_n), 8'd0);
    chk("rst_stage",  8'(bus.stage),      8'd0);
    chk("rst_busy",   8'(bus.busy),       8'd0);
    chk("rst_done",   8'(bus.done),       8'd0);
    chk("rst_marker", 8'(bus.marker),     8'd0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n = 1'b1;
    prev = cur_snap();
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // D=4 full sequence: done at t0+29, busy low at t0+30
    do_start(4, 4, 6, 1'b1, 1'b0, t0);
    wait_drain(60);

    // dwell 0 behaves as 1: done at t0+8
    do_start(0, 1, 6, 1'b1, 1'b0, t0);
    wait_drain(30);

    // abort while stage=2
    do_start(4, 4, 2, 1'b0, 1'b0, t0);
    wait_until(t0 + 10);
    bus.abort = 1'b1;
    push(cyc + 1, 0, 1'b0, 1'b0);
    @(negedge clk);
    bus.abort = 1'b0;
    wait_drain(20);

    // start+abort together in IDLE: no output change at all
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (5) @(negedge clk);

    // D=3 run with a start while busy and dwell changes mid-run
    do_start(3, 3, 6, 1'b1, 1'b0, t0);
    wait_until(t0 + 5);
    bus.dwell_cycles = DW'(7);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(t0 + 12);
    bus.dwell_cycles = DW'(9);
    wait_drain(40);

    // rst_n mid-sequence clears marker too
    do_start(2, 2, 1, 1'b0, 1'b0, t0);
    wait_until(t0 + 4);
    rst_n = 1'b0;
    exp_marker = 1'b0;
    push(cyc + 1, 0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b1;
    wait_drain(10);

`ifdef PT_SEQ_LOOP_EN
    // Looping: done every 15 cycles at D=2, abort during the third pass
    do_start(2, 2, 6, 1'b1, 1'b1, t0);
    run_events(t0 + 15, 2, 6, 1'b0, 1'b1, 1'b1);
    run_events(t0 + 30, 2, 2, 1'b0, 1'b0, 1'b0);
    wait_until(t0 + 36);
    bus.abort = 1'b1;
    push(cyc + 1, 0, 1'b0, 1'b0);
    @(negedge clk);
    bus.abort = 1'b0;
    wait_drain(80);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
